// File: rtl/fpadd_sched_if.sv
// Requester-side bus of the fpadd scheduler.
//   req        : one request line per requester, held until its ack
//   dataa_in   : packed operand A, requester i at [32i+31:32i]
//   datab_in   : packed operand B, same packing
//   ack        : one-hot, one-cycle completion pulse
//   result_out : sum, qualified by ack
//   err        : timeout flag, qualified by ack
//   busy       : scheduler is not idle
// master = requester side, slave = scheduler side.
interface fpadd_sched_if #(
    parameter int NREQ = 4
);
    logic [NREQ-1:0]      req;
    logic [32*NREQ-1:0]   dataa_in;
    logic [32*NREQ-1:0]   datab_in;
    logic [NREQ-1:0]      ack;
    logic [31:0]          result_out;
    logic                 err;
    logic                 busy;

    modport master (
        output req, dataa_in, datab_in,
        input  ack, result_out, err, busy
    );

    modport slave (
        input  req, dataa_in, datab_in,
        output ack, result_out, err, busy
    );
endinterface

// File: rtl/fpadd_sched.sv
// Round-robin scheduler sharing one multi-cycle fpadd unit between NREQ
// requesters. The winner's operands are latched, the adder is started with a
// one-cycle add_start pulse, and the sum (or a qNaN on watchdog timeout) is
// returned with a one-cycle ack to the winner.
//   clk, reset  : clock, asynchronous active-high reset
//   bus         : requester bus (req/operands in, ack/result/err/busy out)
//   add_start   : to fpadd reset pin, one pulse per operation
//   add_dataa/b : registered operands to fpadd
//   add_result  : fpadd sum
//   add_done    : fpadd done level, held until the next start
module fpadd_sched #(
    parameter int NREQ    = 4,
    parameter int IDXW    = 2,
    parameter int TIMEOUT = 15
) (
    input  logic         clk,
    input  logic         reset,
    fpadd_sched_if.slave bus,
    output logic         add_start,
    output logic [31:0]  add_dataa,
    output logic [31:0]  add_datab,
    input  logic [31:0]  add_result,
    input  logic         add_done
);

    localparam int unsigned N    = NREQ;
    localparam logic [7:0]  LAST = 8'(TIMEOUT - 1);
    localparam logic [31:0] QNAN = 32'h7FC0_0000;

    typedef enum logic [1:0] {IDLE, START, WAIT, ACK} state_t;

    state_t            state, state_nx;
    logic [IDXW-1:0]   rr_ptr;
    logic [IDXW-1:0]   gidx;
    logic [IDXW-1:0]   winner;
    logic [IDXW-1:0]   cand;
    logic              found;
    logic [7:0]        count;
    logic [31:0]       result_q;
    logic              err_q;
    logic [31:0]       opa [NREQ];
    logic [31:0]       opb [NREQ];

    always_comb begin
        for (int unsigned i = 0; i < N; i++) begin
            opa[i] = bus.dataa_in[32*i +: 32];
            opb[i] = bus.datab_in[32*i +: 32];
        end
    end

    // First requester after rr_ptr, wrapping; rr_ptr itself is checked last.
    always_comb begin
        found  = 1'b0;
        winner = rr_ptr;
        cand   = '0;
        for (int unsigned k = 1; k <= N; k++) begin
            cand = IDXW'((32'(rr_ptr) + k) % N);
            if (!found && bus.req[cand]) begin
                found  = 1'b1;
                winner = cand;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_nx;
    end

    // add_done is only looked at in WAIT: in START it may still be the stale
    // level left over from the previous operation.
    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (found) state_nx = START;
            START:   state_nx = WAIT;
            WAIT:    if (add_done || count == LAST) state_nx = ACK;
            ACK:     state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rr_ptr    <= IDXW'(NREQ - 1);
            gidx      <= '0;
            add_dataa <= '0;
            add_datab <= '0;
            count     <= '0;
            result_q  <= '0;
            err_q     <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (found) begin
                        gidx      <= winner;
                        rr_ptr    <= winner;
                        add_dataa <= opa[winner];
                        add_datab <= opb[winner];
                    end
                end
                START: count <= '0;
                WAIT: begin
                    if (add_done) begin
                        result_q <= add_result;
                        err_q    <= 1'b0;
                    end else if (count == LAST) begin
                        result_q <= QNAN;
                        err_q    <= 1'b1;
                    end else begin
                        count <= count + 8'd1;
                    end
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        bus.ack = '0;
        if (state == ACK) bus.ack[gidx] = 1'b1;
    end

    assign add_start      = (state == START);
    assign bus.busy       = (state != IDLE);
    assign bus.result_out = result_q;
    assign bus.err        = err_q;

endmodule

// File: doc/fpadd_sched.md
Name: fpadd_sched

Overview:
Round-robin scheduler that shares one multi-cycle fpadd unit between NREQ requesters, e.g. voice mixers and envelope stages in the synth datapath. It latches the winning requester's operands and pulses the adder's start input (fpadd's `reset` pin, which loads operands). It then waits for the adder's `done`, returns the sum with a one-cycle ack to the winner, and enforces a watchdog timeout.

Parameters:
NREQ, 4, number of requesters (2..8)
IDXW, 2, index width, must equal ceil(log2(NREQ))
TIMEOUT, 15, max WAIT cycles before abort (1..255)

Ports:
clk  input  1  clock
reset  input  1  asynchronous, active-high reset
req  input  NREQ  request per requester; held high with operands stable until its ack
dataa_in  input  32*NREQ  operand A, requester i at bits [32i+31:32i]
datab_in  input  32*NREQ  operand B, same packing
ack  output  NREQ  one-hot, one-cycle completion pulse to the granted requester
result_out  output  32  sum, valid while any ack bit is high
err  output  1  high with ack when the operation timed out
busy  output  1  high in every state except IDLE
add_start  output  1  to fpadd reset; high exactly one cycle per operation
add_dataa  output  32  registered operand A to fpadd
add_datab  output  32  registered operand B to fpadd
add_result  input  32  fpadd result
add_done  input  1  fpadd done; level, stays high until the next start

Behaviour:
- Reset (async, takes effect immediately):
  - state=IDLE; ack=0, err=0, busy=0, add_start=0.
  - add_dataa, add_datab and result_out are 0; rr_ptr=NREQ-1; watchdog count=0.
  - Asserting reset mid-operation aborts it with no ack. The adder is left as-is; its stale done is ignored because of the START/WAIT rules below.
- States: IDLE, START, WAIT, ACK.
- IDLE:
  - If req≠0, the winner is the first set bit searching rr_ptr+1, rr_ptr+2, ... modulo NREQ.
  - Latch the winner index into gidx and its operands into add_dataa/add_datab; set rr_ptr=winner; go to START.
  - Otherwise stay in IDLE.
- START:
  - add_start=1 for this cycle only; count=0.
  - add_done is ignored here, since it may be stale from the previous operation.
  - Go to WAIT.
- WAIT:
  - add_start=0. Each cycle, if add_done=1: capture add_result into result_out, err=0, go to ACK.
  - Else if count==TIMEOUT-1: result_out=32'h7FC00000 (qNaN), err=1, go to ACK.
  - Else count=count+1.
- ACK:
  - ack[gidx]=1 for exactly one cycle; result_out and err are valid this cycle; go to IDLE.
  - The requester drops req on the clock edge that ends ACK. In the following IDLE cycle, a req still high counts as a new request.
- Latency: req sampled in IDLE at edge E.
  - START occupies cycle E+1. With an adder whose done rises L cycles after its start edge, ack is high in cycle E+L+2.
  - Back-to-back operations: IDLE→START→WAIT→ACK→IDLE, i.e. WAIT+3 cycles minimum.
- Fairness:
  - Under continuous requests from all NREQ, grants rotate strictly 0,1,...,NREQ-1.
  - No requester waits more than NREQ-1 operations.
- Operands are sampled only in IDLE. Changes to dataa_in/datab_in after the grant do not affect the operation in flight.
- req changes of non-granted requesters during START/WAIT/ACK are ignored until the next IDLE.
- add_dataa and add_datab hold their value between operations.
- Outputs after ack: result_out and err hold their last value. Only ack qualifies them.

Test Plan:
- Single op, fpadd attached: req[0] with A=0x3F800000, B=0x40000000 → one ack[0] pulse, result_out=0x40400000, err=0, exactly one add_start pulse.
- Cancellation: req[2] with A=0x40A00000, B=0xC0A00000 → ack[2], result_out=0x00000000, err=0.
- Round robin: all four req held high (re-asserted after each ack) → grant order 0,1,2,3,0,1; each ack one-hot and one cycle wide; operands match each requester.
- Latency: behavioural adder with L=4, req[1] sampled at edge E → add_start high in cycle E+1, ack[1] high in cycle E+6, busy low again in cycle E+7.
- Timeout: adder model never raises done, TIMEOUT=15 → ack[3] with err=1 and result_out=0x7FC00000 after 15 WAIT cycles; the next request then completes normally.
- Reset mid-WAIT: assert reset with a stale add_done=1 from a prior op → state IDLE, no ack. The next request must not complete before a fresh add_done following its own add_start.
